// File: rtl/coin_feeder.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | coin_feeder : serial coin transmitter and vend checker for the machine  |
// | Revision    : 1.0                                                       |
// +-------------------------------------------------------------------------+
module coin_feeder #(
   parameter int TIMEOUT = 4,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   input  logic [1:0]       req_amount,
   output logic             req_ready,
   input  logic [1:0]       choco,
   output logic             coin_out,
   output logic             done,
   output logic [1:0]       dispensed,
   output logic             error,
   output logic [CNT_W-1:0] vend_count
);

   localparam int WAIT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FEED = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [1:0]          amt_q, amt_d;
   logic [1:0]          rem_q, rem_d;
   logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic                coin_out_q, coin_out_d;
   logic                done_q, done_d;
   logic [1:0]          dispensed_q, dispensed_d;
   logic                error_q, error_d;
   logic [CNT_W-1:0]    vend_count_q, vend_count_d;

   always_comb begin
      state_d      = state_q;
      amt_d        = amt_q;
      rem_d        = rem_q;
      wait_cnt_d   = wait_cnt_q;
      dispensed_d  = dispensed_q;
      error_d      = error_q;
      vend_count_d = vend_count_q;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               amt_d = req_amount;
               rem_d = req_amount;
               if (req_amount == 2'd0) begin
                  state_d     = S_DONE;
                  error_d     = 1'b1;
                  dispensed_d = 2'd0;
               end else begin
                  state_d = S_FEED;
               end
            end
         end
         S_FEED: begin
            if (rem_q == 2'd1) begin
               state_d    = S_WAIT;
               wait_cnt_d = WAIT_W'(1);
            end else begin
               rem_d = rem_q - 2'd1;
            end
         end
         S_WAIT: begin
            // A non-zero code ends the wait even if it arrives in the last cycle.
            if (choco != 2'd0) begin
               state_d     = S_DONE;
               dispensed_d = choco;
               error_d     = (choco != amt_q);
            end else if (wait_cnt_q == WAIT_W'(TIMEOUT)) begin
               state_d     = S_DONE;
               dispensed_d = 2'd0;
               error_d     = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if ((state_d == S_DONE) && !error_d && (vend_count_q != {CNT_W{1'b1}})) begin
         vend_count_d = vend_count_q + CNT_W'(1);
      end

      coin_out_d = (state_d == S_FEED);
      done_d     = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         amt_q        <= 2'd0;
         rem_q        <= 2'd0;
         wait_cnt_q   <= '0;
         coin_out_q   <= 1'b0;
         done_q       <= 1'b0;
         dispensed_q  <= 2'd0;
         error_q      <= 1'b0;
         vend_count_q <= '0;
      end else begin
         state_q      <= state_d;
         amt_q        <= amt_d;
         rem_q        <= rem_d;
         wait_cnt_q   <= wait_cnt_d;
         coin_out_q   <= coin_out_d;
         done_q       <= done_d;
         dispensed_q  <= dispensed_d;
         error_q      <= error_d;
         vend_count_q <= vend_count_d;
      end
   end

   assign req_ready  = (state_q == S_IDLE);
   assign coin_out   = coin_out_q;
   assign done       = done_q;
   assign dispensed  = dispensed_q;
   assign error      = error_q;
   assign vend_count = vend_count_q;

endmodule
`default_nettype wire
